// File: rtl/fft_result_collector.sv
// Buffers one 32-point FFT result frame (re words, then im words) and replays it as (bin, re, im) triples.
// Optional magnitude peak tracking is enabled with `define FFT_PEAK_EN.
module fft_result_collector #(
   parameter int N  = 32,
   parameter int DW = 17
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 finish,
   input  logic [DW-1:0]        answer,
   output logic                 bin_valid_o,
   input  logic                 bin_ready_i,
   output logic [$clog2(N)-1:0] bin_idx_o,
   output logic [DW-1:0]        bin_re_o,
   output logic [DW-1:0]        bin_im_o,
   output logic                 frame_done_o,
   output logic                 overrun_o,
   output logic                 peak_valid_o,
   output logic [$clog2(N)-1:0] peak_bin_o,
   output logic [DW:0]          peak_mag_o
);

   localparam int AW = $clog2(N);
   localparam logic [AW-1:0] LAST = AW'(N - 1);

   typedef enum logic [1:0] {COL_RE, COL_IM, DRAIN} state_t;

   state_t          state, state_nxt;
   logic [AW-1:0]   wcnt, wcnt_nxt;
   logic [AW-1:0]   ridx, ridx_nxt;
   logic            we_re, we_im, last_xfer, in_drain;
   logic [DW-1:0]   re_mem [N];
   logic [DW-1:0]   im_mem [N];

   assign in_drain = (state == DRAIN);

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= COL_RE;
         wcnt         <= '0;
         ridx         <= '0;
         frame_done_o <= 1'b0;
         overrun_o    <= 1'b0;
      end else begin
         state        <= state_nxt;
         wcnt         <= wcnt_nxt;
         ridx         <= ridx_nxt;
         frame_done_o <= last_xfer;
         // The core cannot be stalled, so any word arriving while draining is lost.
         if (in_drain && finish)
            overrun_o <= 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      wcnt_nxt  = wcnt;
      ridx_nxt  = ridx;
      we_re     = 1'b0;
      we_im     = 1'b0;
      last_xfer = 1'b0;
      case (state)
         COL_RE: begin
            if (finish) begin
               we_re = 1'b1;
               if (wcnt == LAST) begin
                  state_nxt = COL_IM;
                  wcnt_nxt  = '0;
               end else begin
                  wcnt_nxt = wcnt + 1'b1;
               end
            end
         end
         COL_IM: begin
            if (finish) begin
               we_im = 1'b1;
               if (wcnt == LAST) begin
                  state_nxt = DRAIN;
                  ridx_nxt  = '0;
               end else begin
                  wcnt_nxt = wcnt + 1'b1;
               end
            end
         end
         DRAIN: begin
            if (bin_ready_i) begin
               if (ridx == LAST) begin
                  state_nxt = COL_RE;
                  wcnt_nxt  = '0;
                  last_xfer = 1'b1;
               end else begin
                  ridx_nxt = ridx + 1'b1;
               end
            end
         end
         default: begin
            state_nxt = COL_RE;
            wcnt_nxt  = '0;
            ridx_nxt  = '0;
         end
      endcase
   end

   // Frame buffer is not reset; its contents are meaningless until refilled.
   always_ff @(posedge clk) begin
      if (we_re)
         re_mem[wcnt] <= answer;
      if (we_im)
         im_mem[wcnt] <= answer;
   end

   assign bin_valid_o = in_drain;
   assign bin_idx_o   = in_drain ? ridx : '0;
   assign bin_re_o    = in_drain ? re_mem[ridx] : '0;
   assign bin_im_o    = in_drain ? im_mem[ridx] : '0;

`ifdef FFT_PEAK_EN
   logic [DW:0]   mag, pk_mag;
   logic [AW-1:0] pk_bin;

   // DW+1 bits so that |-2^(DW-1)| is representable.
   function automatic logic [DW:0] absv(input logic [DW-1:0] v);
      absv = v[DW-1] ? ({1'b0, ~v} + {{DW{1'b0}}, 1'b1}) : {1'b0, v};
   endfunction

   // re[wcnt] was written during COL_RE, so it pairs with the incoming imag word.
   assign mag = absv(re_mem[wcnt]) + absv(answer);

   always_ff @(posedge clk) begin
      if (rst) begin
         pk_mag <= '0;
         pk_bin <= '0;
      end else if (state == COL_RE && state_nxt == COL_IM) begin
         pk_mag <= '0;
         pk_bin <= '0;
      end else if (we_im && mag > pk_mag) begin
         // Strict compare: ties keep the lower bin.
         pk_mag <= mag;
         pk_bin <= wcnt;
      end
   end

   assign peak_valid_o = in_drain;
   assign peak_bin_o   = in_drain ? pk_bin : '0;
   assign peak_mag_o   = in_drain ? pk_mag : '0;
`else
   assign peak_valid_o = 1'b0;
   assign peak_bin_o   = '0;
   assign peak_mag_o   = '0;
`endif

endmodule

// File: tb/tb_fft_result_collector.sv
// Directed bench for fft_result_collector: contiguous, gapped, backpressure, overrun, reset and peak cases.
module tb_fft_result_collector;
   localparam int N  = 32;
   localparam int DW = 17;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          rst, finish, bin_ready_i;
   logic [DW-1:0] answer;
   logic          bin_valid_o, frame_done_o, overrun_o, peak_valid_o;
   logic [AW-1:0] bin_idx_o, peak_bin_o;
   logic [DW-1:0] bin_re_o, bin_im_o;
   logic [DW:0]   peak_mag_o;

   int pass_cnt = 0;
   int chk_cnt  = 0;

   logic [DW-1:0] fre [N];
   logic [DW-1:0] fim [N];
   int            exp_pbin, exp_pmag;

   fft_result_collector #(.N(N), .DW(DW)) dut (
      .clk(clk), .rst(rst), .finish(finish), .answer(answer),
      .bin_valid_o(bin_valid_o), .bin_ready_i(bin_ready_i), .bin_idx_o(bin_idx_o),
      .bin_re_o(bin_re_o), .bin_im_o(bin_im_o), .frame_done_o(frame_done_o),
      .overrun_o(overrun_o), .peak_valid_o(peak_valid_o), .peak_bin_o(peak_bin_o),
      .peak_mag_o(peak_mag_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_valid"}, bin_valid_o, 0);
      chk({tag, "_out"}, {bin_idx_o, bin_re_o, bin_im_o}, 0);
      chk({tag, "_peak"}, {peak_valid_o, peak_bin_o, peak_mag_o}, 0);
   endtask

   task automatic fill_ramp(input int re_off, input int im_off);
      for (int k = 0; k < N; k++) begin
         fre[k] = 17'(k + re_off);
         fim[k] = 17'(im_off - k);
      end
   endtask

   // Entered and left at a negedge.
   task automatic send_frame(input bit gapped);
      bit early = 0;
      for (int i = 0; i < 2*N; i++) begin
         if (gapped) begin
            @(negedge clk);
            finish = 0;
            if (bin_valid_o) early = 1;
         end
         @(negedge clk);
         if (bin_valid_o) early = 1;
         finish = 1;
         answer = (i < N) ? fre[i] : fim[i-N];
      end
      @(negedge clk);
      finish = 0;
      answer = '0;
      chk("no_early_valid", early, 0);
      chk("valid_after_last", bin_valid_o, 1);
   endtask

   task automatic chk_peak();
`ifdef FFT_PEAK_EN
      chk("peak_valid", peak_valid_o, 1);
      chk("peak_bin", peak_bin_o, exp_pbin);
      chk("peak_mag", peak_mag_o, exp_pmag);
`else
      chk("peak_off", {peak_valid_o, peak_bin_o, peak_mag_o}, 0);
`endif
   endtask

   task automatic drain(input int stall_bin, input int ovr_bin);
      int cnt = 0, stalls = 0, ovr = 0;
      bit done = 0;
      for (int cyc = 0; cyc < 200 && !done; cyc++) begin
         if (ovr_bin >= 0 && cnt >= ovr_bin && ovr < 2) begin
            finish = 1;
            answer = 17'h1abcd;
            ovr++;
         end else begin
            finish = 0;
            answer = '0;
         end
         if (bin_valid_o) begin
            chk("idx", bin_idx_o, cnt);
            chk("re", bin_re_o, fre[cnt]);
            chk("im", bin_im_o, fim[cnt]);
            if (cnt == 0 || cnt == N-1) chk_peak();
         end
         if (cnt == stall_bin && stalls < 3) begin
            bin_ready_i = 0;
            stalls++;
         end else begin
            bin_ready_i = 1;
         end
         if (bin_valid_o && bin_ready_i) begin
            cnt++;
            if (cnt == N) done = 1;
         end
         @(negedge clk);
      end
      bin_ready_i = 0;
      finish = 0;
      chk("xfer_cnt", cnt, N);
      if (stall_bin >= 0) chk("stall_cycles", stalls, 3);
      chk("frame_done_pulse", frame_done_o, 1);
      chk_idle("after_drain");
      @(negedge clk);
      chk("frame_done_clear", frame_done_o, 0);
   endtask

   initial begin
      rst = 1; finish = 0; answer = '0; bin_ready_i = 0;
      repeat (2) @(negedge clk);
      chk_idle("reset");
      chk("reset_done", frame_done_o, 0);
      chk("reset_ovr", overrun_o, 0);
      rst = 0;

      // Contiguous ramp: re=k, im=-k, peak |k|+|k| largest at bin 31.
      fill_ramp(0, 0);
      exp_pbin = 31; exp_pmag = 62;
      send_frame(0);
      drain(-1, -1);
      chk("ovr_clean", overrun_o, 0);
      chk("bin5_re", fre[5], 17'd5);

      // Gapped input.
      send_frame(1);
      drain(-1, -1);

      // Backpressure at bin 7.
      send_frame(0);
      drain(7, -1);
      chk("ovr_clean2", overrun_o, 0);

      // Overrun: two words dropped during drain.
      send_frame(0);
      drain(-1, 10);
      chk("ovr_set", overrun_o, 1);
      // re=k+100, im=k-50: |re|+|im| = 150 for all bins, tie keeps bin 0.
      fill_ramp(100, 0);
      for (int k = 0; k < N; k++) fim[k] = 17'(k - 50);
      exp_pbin = 0; exp_pmag = 150;
      send_frame(0);
      drain(-1, -1);
      chk("ovr_held", overrun_o, 1);

      // Reset after 40 words of a junk frame.
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         finish = 1;
         answer = 17'(i + 7);
      end
      @(negedge clk);
      finish = 0;
      rst = 1;
      @(negedge clk);
      chk_idle("mid_reset");
      chk("mid_reset_ovr", overrun_o, 0);
      chk("mid_reset_done", frame_done_o, 0);
      rst = 0;
      fill_ramp(0, 0);
      exp_pbin = 31; exp_pmag = 62;
      send_frame(0);
      drain(-1, -1);

      // Peak: bin 9 |-65536|+0 ties bin 20 30000+35536; lower bin kept.
      for (int k = 0; k < N; k++) begin
         fre[k] = '0;
         fim[k] = '0;
      end
      fre[9]  = 17'(-65536);
      fre[20] = 17'd30000;
      fim[20] = 17'd35536;
      exp_pbin = 9; exp_pmag = 65536;
      send_frame(0);
      drain(-1, -1);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule

// File: doc/fft_result_collector.md
# fft_result_collector

Receive-side companion to the 32-point FFT core. It captures the core's serial result stream: 64 words on `answer` while `finish` is high, with 32 real parts in bin order followed by 32 imaginary parts. It buffers one full frame and replays it downstream as one (bin, re, im) triple per bin over a valid/ready handshake. It sits directly on the FFT core's output, between the core and any bin-level consumer (magnitude, detection, host readout).

## Interface
- `N`, 32, bins per frame (power of two; frame = 2*N words)
- `DW`, 17, result word width (two's complement, as produced by the FFT core)
- `clk`  input  1  single clock, all logic on rising edge
- `rst`  input  1  synchronous, active-high reset
- `finish`  input  1  core output-valid; one word accepted per cycle it is high
- `answer`  input  DW  core result word
- `bin_valid_o`  output  1  triple on `bin_*` is valid
- `bin_ready_i`  input  1  downstream accepts triple
- `bin_idx_o`  output  log2(N)  bin index 0..N-1
- `bin_re_o`  output  DW  real part of bin
- `bin_im_o`  output  DW  imaginary part of bin
- `frame_done_o`  output  1  one-cycle pulse after last bin transferred
- `overrun_o`  output  1  sticky: a word arrived while draining and was dropped
- `peak_valid_o`  output  1  peak result valid (FFT_PEAK_EN only, else 0)
- `peak_bin_o`  output  log2(N)  bin of largest |re|+|im| (else 0)
- `peak_mag_o`  output  DW+1  |re|+|im| of that bin, unsigned (else 0)

## Operation
- States: COL_RE, COL_IM, DRAIN. Reset state COL_RE; word counter `wcnt` = 0.
- COL_RE:
  - each cycle with `finish`=1, store `answer` in re[wcnt] and increment.
  - After word N-1 is stored: go to COL_IM, `wcnt` = 0.
- COL_IM:
  - same accept rule, stores im[wcnt].
  - After word N-1 is stored: go to DRAIN, read index `ridx` = 0.
- `finish` gaps are legal in both collect states; the counter simply holds.
- DRAIN:
  - `bin_valid_o`=1; `bin_idx_o`=ridx, `bin_re_o`=re[ridx], `bin_im_o`=im[ridx].
  - Transfer occurs when `bin_valid_o` && `bin_ready_i`; then `ridx`++.
  - On the transfer of bin N-1: go to COL_RE, `wcnt` = 0, and `frame_done_o` pulses in the following cycle.
- Backpressure: while `bin_valid_o`=1 and `bin_ready_i`=0, all `bin_*` outputs hold stable.
- Overrun: the core cannot be stalled. `finish`=1 in any DRAIN cycle, including the final-transfer cycle, drops the word and sets `overrun_o`. It stays set until `rst`.
- Reset at any point: state COL_RE, counters 0, partial or buffered frame discarded. Buffer contents are not cleared; they are don't-care.
- Reset values: `bin_valid_o`=0, `bin_idx_o`=0, `bin_re_o`=0, `bin_im_o`=0, `frame_done_o`=0, `overrun_o`=0, `peak_valid_o`=0, `peak_bin_o`=0, `peak_mag_o`=0.
- Outside DRAIN, `bin_re_o`/`bin_im_o`/`bin_idx_o` are driven 0.

## Timing
- Accept latency: a word sampled at edge t is stored by edge t.
- With contiguous input, word 2N-1 is sampled at edge k. Then `bin_valid_o`=1 from cycle k+1 (registered state).
- Drain throughput: 1 bin/cycle with `bin_ready_i` held high. The full drain takes N cycles.
- `frame_done_o` is high exactly one cycle, in the cycle after the final transfer. In that same cycle the block is in COL_RE and can already accept the next frame's word 0.
- Minimum frame period with no overrun: 2N + N cycles.

## Configuration
- Macro `FFT_PEAK_EN`.
- Defined, magnitude tracking:
  - During COL_IM, each accepted imag word k forms mag = |re[k]| + |im[k]|, DW+1 bits unsigned (|−2^(DW−1)| = 2^(DW−1) fits).
  - A running maximum replaces the held peak only when mag is strictly greater, so ties keep the lower bin.
  - The maximum is cleared on entry to COL_IM.
  - `peak_valid_o` rises with the DRAIN entry cycle and falls on exit.
  - `peak_bin_o`/`peak_mag_o` are stable throughout DRAIN.
- Undefined: no magnitude logic is synthesized. The peak ports remain on the interface, tied to 0.

## Test plan
- Contiguous frame: re[k]=k, im[k]=−k, `bin_ready_i`=1 → 32 transfers in bins 0..31, where bin 5 = (5, −5). `frame_done_o` pulses one cycle after bin 31. `overrun_o`=0.
- Gapped input: `finish` toggled 1/0 across 128 cycles → same 32 triples as the contiguous case. `bin_valid_o` only after the 64th accepted word.
- Backpressure: `bin_ready_i`=0 for 3 cycles at bin 7 → bin 7 outputs held stable for those cycles. The total transfer count is still exactly 32.
- Overrun: `finish`=1 for 2 cycles during DRAIN → `overrun_o`=1 and held. The drained data is unchanged, and the next frame's bin 0 comes from words arriving after DRAIN exits.
- Reset mid-frame: `rst` after 40 words, then a fresh 64-word frame → all outputs 0 after reset. Only the fresh frame is drained.
- FFT_PEAK_EN: re[9]=−65536 and im[9]=0, re[20]=30000 and im[20]=35536, all other words 0 → `peak_bin_o`=9, `peak_mag_o`=65536. Bin 20 ties at 65536 and bin 9 is kept because it is lower. `peak_valid_o` is high exactly during DRAIN.
